// File: rtl/fetch_ctrl.sv
// fetch_ctrl: PC sequencing and single-outstanding AXI instruction fetch
// feeding the IF/ID register, with redirect kill and load-use hold buffer.
module fetch_ctrl #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [31:0]       NOP_INST = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_cur,
  output logic [ADDR_W-1:0] pc_next,
  output logic              pc_write,
  output logic              pc_stall,
  input  logic              hazard_stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              ar_valid,
  output logic [ADDR_W-1:0] ar_addr,
  input  logic              ar_ready,
  input  logic              r_valid,
  input  logic [31:0]       r_data,
  input  logic [1:0]        r_resp,
  output logic              r_ready,
  output logic              inst_valid,
  output logic [31:0]       inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              fetch_err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

  logic [1:0]        state_q, state_d;
  logic              kill_q, kill_d;
  logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
  logic [31:0]       buf_inst_q, buf_inst_d;
  logic [ADDR_W-1:0] buf_pc_q, buf_pc_d;
  logic              ar_valid_q, ar_valid_d;
  logic              inst_valid_q, inst_valid_d;
  logic [31:0]       inst_q, inst_d;
  logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
  logic              err_q, err_d;

  logic [31:0]       beat_inst;
  logic              beat_err;
  logic              redirect_lsb_unused;

  // Redirect targets are word aligned; the low bits are dropped.
  assign redirect_lsb_unused = ^redirect_pc[1:0];

  assign beat_err  = (r_resp != 2'b00);
  assign beat_inst = beat_err ? NOP_INST : r_data;

  // Next-state, PC control and IF/ID payload selection.
  always_comb begin
    state_d      = state_q;
    kill_d       = kill_q;
    fetch_addr_d = fetch_addr_q;
    buf_inst_d   = buf_inst_q;
    buf_pc_d     = buf_pc_q;
    inst_valid_d = 1'b0;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    err_d        = err_q;
    pc_write     = 1'b0;
    pc_next      = fetch_addr_q;

    case (state_q)
      ST_IDLE: state_d = ST_REQ;
      ST_REQ: begin
        // The address phase is never withdrawn; a redirect marks the
        // in-flight fetch stale instead.
        if (redirect_valid) kill_d = 1'b1;
        if (ar_ready)       state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (redirect_valid) begin
          if (r_valid) begin
            kill_d  = 1'b0;
            state_d = ST_REQ;
          end else begin
            kill_d  = 1'b1;
          end
        end else if (r_valid) begin
          if (kill_q) begin
            kill_d  = 1'b0;
            state_d = ST_REQ;
          end else begin
            if (beat_err) err_d = 1'b1;
            if (hazard_stall) begin
              buf_inst_d = beat_inst;
              buf_pc_d   = fetch_addr_q;
              state_d    = ST_HOLD;
            end else begin
              inst_valid_d = 1'b1;
              inst_d       = beat_inst;
              inst_pc_d    = fetch_addr_q;
              pc_write     = 1'b1;
              pc_next      = fetch_addr_q + PC_STEP;
              state_d      = ST_REQ;
            end
          end
        end
      end
      ST_HOLD: begin
        if (redirect_valid) begin
          state_d = ST_REQ;
        end else if (!hazard_stall) begin
          inst_valid_d = 1'b1;
          inst_d       = buf_inst_q;
          inst_pc_d    = buf_pc_q;
          pc_write     = 1'b1;
          pc_next      = buf_pc_q + PC_STEP;
          state_d      = ST_REQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (redirect_valid && (state_q != ST_IDLE)) begin
      pc_write = 1'b1;
      pc_next  = {redirect_pc[ADDR_W-1:2], 2'b00};
    end

    // The PC register loads pc_next on this same edge, so on entry to REQ
    // the value it will hold is taken directly rather than a cycle late.
    if ((state_d == ST_REQ) && (state_q != ST_REQ)) begin
      fetch_addr_d = pc_write ? pc_next : pc_cur;
    end

    ar_valid_d = (state_d == ST_REQ);
  end

  // State and registered outputs; reset abandons any outstanding beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      kill_q       <= 1'b0;
      fetch_addr_q <= RESET_PC;
      buf_inst_q   <= NOP_INST;
      buf_pc_q     <= RESET_PC;
      ar_valid_q   <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_q       <= NOP_INST;
      inst_pc_q    <= RESET_PC;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      kill_q       <= kill_d;
      fetch_addr_q <= fetch_addr_d;
      buf_inst_q   <= buf_inst_d;
      buf_pc_q     <= buf_pc_d;
      ar_valid_q   <= ar_valid_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      err_q        <= err_d;
    end
  end

  assign pc_stall   = ~pc_write;
  assign r_ready    = (state_q == ST_WAIT);
  assign ar_valid   = ar_valid_q;
  assign ar_addr    = fetch_addr_q;
  assign inst_valid = inst_valid_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign fetch_err  = err_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: random AXI slave, PC register and instruction-stream
// reference model for fetch_ctrl, plus directed scenarios.
module tb_fetch_ctrl;
  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] RPC1 = 32'hFFFF_FFFC;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT 0 (RESET_PC = 0)
  logic        rst, pc_write, pc_stall, hazard_stall, redirect_valid;
  logic [31:0] pc_cur, pc_next, redirect_pc, ar_addr, r_data, inst, inst_pc;
  logic        ar_valid, ar_ready, r_valid, r_ready, inst_valid, fetch_err;
  logic [1:0]  r_resp;

  // DUT 1 (RESET_PC = FFFF_FFFC)
  logic        rst_1, pc_write_1, pc_stall_1, hazard_stall_1, redirect_valid_1;
  logic [31:0] pc_cur_1, pc_next_1, redirect_pc_1, ar_addr_1, r_data_1, inst_1, inst_pc_1;
  logic        ar_valid_1, ar_ready_1, r_valid_1, r_ready_1, inst_valid_1, fetch_err_1;
  logic [1:0]  r_resp_1;

  fetch_ctrl #(.ADDR_W(32), .RESET_PC(32'h0000_0000), .NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst), .pc_cur(pc_cur), .pc_next(pc_next), .pc_write(pc_write),
    .pc_stall(pc_stall), .hazard_stall(hazard_stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .ar_valid(ar_valid), .ar_addr(ar_addr), .ar_ready(ar_ready),
    .r_valid(r_valid), .r_data(r_data), .r_resp(r_resp), .r_ready(r_ready),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .fetch_err(fetch_err));

  fetch_ctrl #(.ADDR_W(32), .RESET_PC(RPC1), .NOP_INST(NOP)) dut_1 (
    .clk(clk), .rst(rst_1), .pc_cur(pc_cur_1), .pc_next(pc_next_1), .pc_write(pc_write_1),
    .pc_stall(pc_stall_1), .hazard_stall(hazard_stall_1), .redirect_valid(redirect_valid_1),
    .redirect_pc(redirect_pc_1), .ar_valid(ar_valid_1), .ar_addr(ar_addr_1), .ar_ready(ar_ready_1),
    .r_valid(r_valid_1), .r_data(r_data_1), .r_resp(r_resp_1), .r_ready(r_ready_1),
    .inst_valid(inst_valid_1), .inst(inst_1), .inst_pc(inst_pc_1), .fetch_err(fetch_err_1));

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Environment knobs
  int          ar_wait_cfg, r_wait_cfg;
  int          ar_wait_q[$];
  bit          rand_hz, rand_rd, rand_err;
  logic [31:0] mem_key;
  bit          hz_arm;  logic [31:0] hz_addr; int hz_len;
  bit          rd_arm;  logic [31:0] rd_addr, rd_target;
  bit          err_arm; logic [31:0] err_addr;

  // Slave and model state
  bit          pend, ar_started, started, prev_ar_wait, err_seen;
  logic [31:0] pend_addr, prev_ar_addr, exp_pc;
  int          ar_cnt, r_cnt, hz_cnt, cyc;
  logic [31:0] ar_log[$], ar_cyc[$], iv_pc[$], iv_inst[$], iv_cyc[$], pw_cyc[$], ar1_log[$];

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ mem_key;
  endfunction

  function automatic bit is_err(input logic [31:0] a);
    return (err_arm && a == err_addr) || (rand_err && a[6:2] == 5'd9);
  endfunction

  function automatic logic [31:0] qat(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 'x;
  endfunction

  task automatic set_directed();
    ar_wait_cfg = 0; r_wait_cfg = 0; ar_wait_q.delete();
    rand_hz = 0; rand_rd = 0; rand_err = 0; mem_key = '0;
    hz_arm = 0; rd_arm = 0; err_arm = 0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    ar_ready = 0; r_valid = 0; r_data = '0; r_resp = '0;
    hazard_stall = 0; redirect_valid = 0; redirect_pc = '0;
    pc_cur = '0;
    pend = 0; ar_started = 0; started = 0; prev_ar_wait = 0; err_seen = 0;
    ar_cnt = 0; r_cnt = 0; hz_cnt = 0; cyc = 0; exp_pc = '0;
    ar_log.delete(); ar_cyc.delete(); iv_pc.delete(); iv_inst.delete();
    iv_cyc.delete(); pw_cyc.delete();
    #1;
    check("rst_ar_valid", ar_valid, 0);
    check("rst_r_ready", r_ready, 0);
    check("rst_inst_valid", inst_valid, 0);
    check("rst_inst", inst, NOP);
    check("rst_inst_pc", inst_pc, 0);
    check("rst_pc_write", pc_write, 0);
    check("rst_pc_next", pc_next, 0);
    check("rst_fetch_err", fetch_err, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
  endtask

  // One clock of DUT 0: drive at posedge+1, check at negedge.
  task automatic step();
    bit rd_now, pcw;
    logic [31:0] tgt, pcn;
    rd_now = 0; tgt = '0;
    if (ar_valid) started = 1'b1;
    if (ar_valid && !ar_started) begin
      ar_started = 1'b1;
      if (ar_wait_q.size() > 0) ar_cnt = ar_wait_q.pop_front();
      else ar_cnt = (ar_wait_cfg < 0) ? int'($urandom_range(0, 3)) : ar_wait_cfg;
    end
    ar_ready = ar_valid ? (ar_cnt == 0) : 1'($urandom_range(0, 1));
    r_valid  = pend && (r_cnt == 0);
    r_data   = r_valid ? mem(pend_addr) : $urandom;
    r_resp   = r_valid ? (is_err(pend_addr) ? 2'b10 : 2'b00) : 2'($urandom_range(0, 3));
    if (hz_arm && r_valid && pend_addr == hz_addr) begin
      hz_cnt = hz_len; hz_arm = 0;
    end
    hazard_stall = (hz_cnt > 0) || (rand_hz && $urandom_range(0, 3) == 0);
    if (rd_arm && pend && pend_addr == rd_addr && r_cnt > 0) begin
      rd_now = 1; tgt = rd_target; rd_arm = 0;
    end else if (rand_rd && started && $urandom_range(0, 15) == 0) begin
      rd_now = 1; tgt = $urandom & 32'h0000_03FF;
    end
    redirect_valid = rd_now;
    redirect_pc    = rd_now ? tgt : $urandom;

    @(negedge clk);
    check("pc_stall", pc_stall, !pc_write);
    if (prev_ar_wait) begin
      check("ar_valid_hold", ar_valid, 1);
      check("ar_addr_hold", ar_addr, prev_ar_addr);
    end
    if (inst_valid) begin
      check("inst_pc", inst_pc, exp_pc);
      check("inst", inst, is_err(exp_pc) ? NOP : mem(exp_pc));
      check("pc_after", pc_cur, exp_pc + 32'd4);
      if (is_err(exp_pc)) err_seen = 1;
      iv_pc.push_back(inst_pc); iv_inst.push_back(inst); iv_cyc.push_back(cyc);
      exp_pc = exp_pc + 32'd4;
    end
    if (err_seen) check("fetch_err", fetch_err, 1);
    if (pc_write) pw_cyc.push_back(cyc);
    if (rd_now) exp_pc = {tgt[31:2], 2'b00};
    pcw = pc_write; pcn = pc_next;
    if (pend && r_cnt > 0) r_cnt--;
    if (r_valid && r_ready) pend = 0;
    if (hz_cnt > 0) hz_cnt--;
    prev_ar_wait = ar_valid && !ar_ready;
    prev_ar_addr = ar_addr;
    if (ar_valid && ar_ready) begin
      ar_log.push_back(ar_addr); ar_cyc.push_back(cyc);
      ar_started = 0; pend = 1; pend_addr = ar_addr;
      r_cnt = (r_wait_cfg < 0) ? int'($urandom_range(0, 4)) : r_wait_cfg;
    end else if (ar_valid && ar_cnt > 0) begin
      ar_cnt--;
    end

    @(posedge clk); #1;
    if (pcw) pc_cur = pcn;
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // One clock of DUT 1 with an always-ready slave.
  task automatic step1(input bit rv);
    bit pcw;
    logic [31:0] pcn;
    r_valid_1 = rv;
    r_data_1  = $urandom;
    @(negedge clk);
    check("pc_stall_1", pc_stall_1, !pc_write_1);
    if (ar_valid_1 && ar_ready_1) ar1_log.push_back(ar_addr_1);
    pcw = pc_write_1; pcn = pc_next_1;
    @(posedge clk); #1;
    if (pcw) pc_cur_1 = pcn;
  endtask

  initial begin
    rst = 1'b1; rst_1 = 1'b1;
    pc_cur_1 = RPC1; hazard_stall_1 = 0; redirect_valid_1 = 0; redirect_pc_1 = '0;
    ar_ready_1 = 1; r_valid_1 = 0; r_data_1 = '0; r_resp_1 = 2'b00;
    set_directed();
    #2;
    rst_1 = 1'b0;

    // Sequential fetch, data = address
    do_reset();
    run(10);
    for (int i = 0; i < 4; i++) begin
      check("seq_ar_addr", qat(ar_log, i), 32'(4 * i));
      check("seq_inst_pc", qat(iv_pc, i), 32'(4 * i));
    end
    for (int i = 0; i < 3; i++)
      check("seq_iv_gap", qat(iv_cyc, i + 1) - qat(iv_cyc, i), 2);
    check("seq_fetch_err", fetch_err, 0);

    // ar_ready low for 3 cycles on the second request
    set_directed();
    ar_wait_q.push_back(0); ar_wait_q.push_back(3);
    do_reset();
    run(10);
    check("arstall_hs_cyc", qat(ar_cyc, 1), 6);
    check("arstall_addr", qat(ar_log, 1), 32'h4);
    check("arstall_pw_cyc", qat(pw_cyc, 1), 7);

    // Load-use hold at PC 0x8
    set_directed();
    mem_key = 32'h00A0_009B;
    hz_arm = 1; hz_addr = 32'h8; hz_len = 4;
    do_reset();
    run(10);
    check("hold_pc", pc_cur, 32'h8);
    check("hold_iv", inst_valid, 0);
    run(6);
    check("hold_iv_cyc", qat(iv_cyc, 2), 11);
    check("hold_inst", qat(iv_inst, 2), 32'h00A0_0093);
    check("hold_inst_pc", qat(iv_pc, 2), 32'h8);
    check("hold_pw_cyc", qat(pw_cyc, 2), 10);
    check("hold_next_ar", qat(ar_log, 3), 32'hC);

    // Redirect to 0x103 while waiting for the 0x4 beat
    set_directed();
    r_wait_cfg = 2;
    rd_arm = 1; rd_addr = 32'h4; rd_target = 32'h103;
    do_reset();
    run(24);
    check("redir_ar", qat(ar_log, 2), 32'h100);
    check("redir_inst_pc", qat(iv_pc, 1), 32'h100);

    // Error response on the fetch at 0x10
    set_directed();
    err_arm = 1; err_addr = 32'h10;
    do_reset();
    run(10);
    check("err_before", fetch_err, 0);
    run(6);
    check("err_set", fetch_err, 1);
    check("err_inst", qat(iv_inst, 4), NOP);
    check("err_inst_pc", qat(iv_pc, 4), 32'h10);
    check("err_next_ar", qat(ar_log, 5), 32'h14);
    run(6);
    check("err_sticky", fetch_err, 1);

    // Randomized traffic with mid-run reset
    set_directed();
    ar_wait_cfg = -1; r_wait_cfg = -1;
    rand_hz = 1; rand_rd = 1; rand_err = 1; mem_key = $urandom;
    do_reset();
    run(1500);
    do_reset();
    run(1500);
    check("rand_progress", 32'(iv_pc.size() > 100), 1);

    // RESET_PC wrap and reset mid-WAIT on DUT 1
    check("rst1_ar_valid", ar_valid_1, 0);
    check("rst1_inst", inst_1, NOP);
    check("rst1_inst_pc", inst_pc_1, RPC1);
    check("rst1_pc_next", pc_next_1, RPC1);
    check("rst1_fetch_err", fetch_err_1, 0);
    rst_1 = 1'b1;
    step1(1); step1(1); step1(1); step1(1);
    check("wrap_first_ar", qat(ar1_log, 0), RPC1);
    check("wrap_second_ar", qat(ar1_log, 1), 32'h0);
    check("wrap_pc", pc_cur_1, 32'h0);
    check("wrap_inst_pc", inst_pc_1, RPC1);
    r_valid_1 = 0;
    check("wait_r_ready", r_ready_1, 1);
    @(negedge clk);
    rst_1 = 1'b0;
    pc_cur_1 = RPC1;
    #1;
    check("midrst_r_ready", r_ready_1, 0);
    check("midrst_ar_valid", ar_valid_1, 0);
    check("midrst_inst_valid", inst_valid_1, 0);
    @(posedge clk); #1;
    rst_1 = 1'b1;
    ar1_log.delete();
    step1(1); step1(1); step1(1);
    check("midrst_first_ar", qat(ar1_log, 0), RPC1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Sequences the program counter and instruction fetch for the AXI-attached CPU core.
- Sits between the PC register, the instruction-side AXI read channel (AR/R) and the IF/ID pipeline register.
- Decides when the PC advances, to what value, and when it holds.
- Arbitrates between sequential fetch, branch/jump redirects and load-use hazard stalls, and discards fetches made stale by a redirect.

Parameters:
ADDR_W, 32, width of PC and AXI address
RESET_PC, 32'h0000_0000, first fetch address after reset (must equal the PC register reset value)
NOP_INST, 32'h0000_0013, instruction sent to IF/ID on an error response

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
pc_cur  in  ADDR_W  current PC register output
pc_next  out  ADDR_W  value written into PC when pc_write=1
pc_write  out  1  PC load enable
pc_stall  out  1  PC hold; always equals ~pc_write
hazard_stall  in  1  load-use stall from ID; IF/ID cannot accept
redirect_valid  in  1  taken branch/jump from EX, one-cycle pulse
redirect_pc  in  ADDR_W  redirect target
ar_valid  out  1  AXI read address valid
ar_addr  out  ADDR_W  AXI read address
ar_ready  in  1  AXI read address ready
r_valid  in  1  AXI read data valid
r_data  in  32  AXI read data
r_resp  in  2  AXI read response
r_ready  out  1  AXI read data ready
inst_valid  out  1  instruction valid to IF/ID
inst  out  32  instruction to IF/ID
inst_pc  out  ADDR_W  PC of inst
fetch_err  out  1  sticky error flag: a non-OKAY response was seen

Behaviour:
Reset (rst=0, asynchronous):
- State IDLE; ar_valid=0, r_ready=0, inst_valid=0.
- inst=NOP_INST, inst_pc=RESET_PC, pc_write=0, pc_next=RESET_PC.
- Internal regs: kill=0, fetch_err=0, fetch_addr=RESET_PC, buffer empty.
- Reset mid-transaction aborts immediately. The outstanding AXI beat is abandoned, because the slave shares the reset.

States: IDLE, REQ, WAIT, HOLD.
- IDLE: one cycle after reset release, then REQ.
- REQ:
  - ar_valid=1; ar_addr=fetch_addr, latched from pc_cur on entry.
  - ar_addr is stable while ar_valid=1 and ar_ready=0. ar_valid is never dropped before handshake.
  - On ar_valid & ar_ready: go to WAIT.
- WAIT:
  - r_ready=1.
  - On r_valid & kill: discard the beat, clear kill, go to REQ.
  - On r_valid & ~kill & ~hazard_stall: inst_valid=1 for one cycle, inst=r_data, inst_pc=fetch_addr; pc_write=1, pc_next=fetch_addr+4 (mod 2^ADDR_W, wraps); go to REQ.
  - On r_valid & ~kill & hazard_stall: capture r_data/fetch_addr into the buffer, pc_write=0, go to HOLD.
- HOLD:
  - inst_valid=0 while hazard_stall=1.
  - First cycle with hazard_stall=0: present the buffer with inst_valid=1, pc_write=1, pc_next=buffer_pc+4, go to REQ.

Redirect (highest priority, any state except IDLE):
- pc_write=1, pc_next={redirect_pc[ADDR_W-1:2],2'b00}.
- inst_valid forced to 0 that cycle.
- In REQ, or in WAIT without r_valid: set kill=1. Only one fetch is ever outstanding.
- In WAIT with r_valid the same cycle: the beat is discarded and no kill is needed; go to REQ.
- In HOLD: discard the buffer, go to REQ.
- A second redirect while kill=1: the latest target wins; kill stays 1.
- Redirect overrides hazard_stall.

Error responses:
- r_resp≠2'b00 on an accepted, unkilled beat: inst=NOP_INST, fetch_err set to 1 until reset.
- The PC still advances by 4.

Throughput and latency:
- Minimum two cycles per instruction: REQ with ar_ready, then WAIT with r_valid.
- PC updates at the clock edge after pc_write. The next REQ latches the new pc_cur.

Output timing:
- All outputs are registered, except pc_write, pc_next, pc_stall and r_ready, which are combinational from state and inputs.
- The PC register must never see pc_write=1 and pc_stall=1 together.

Test Plan:
- Reset release, slave always ready, data = address: ar_addr sequence 0,4,8,C; inst_valid every 2nd cycle with inst_pc 0,4,8,C; fetch_err=0.
- ar_ready held low 3 cycles in REQ: ar_valid=1 and ar_addr=0x4 constant across those cycles; no pc_write until r_valid.
- hazard_stall=1 for 4 cycles, starting the cycle r_valid returns 0x00A00093 at PC 0x8: HOLD entered, inst_valid=0, PC stays 0x8. On release, inst=0x00A00093, inst_pc=0x8, PC becomes 0xC.
- redirect_valid with redirect_pc=0x103 while in WAIT before r_valid: the returned beat is not forwarded; next ar_addr=0x100; the first inst_valid carries inst_pc=0x100.
- r_resp=2'b10 on the fetch at 0x10: inst=0x00000013, fetch_err=1 and it stays 1; the next ar_addr is 0x14.
- Counter wrap with RESET_PC=32'hFFFF_FFFC: after the first fetch, ar_addr=0x0. Then assert rst low mid-WAIT: ar_valid=0 and inst_valid=0 immediately, and after release the first ar_addr=RESET_PC.
